// File: rtl/enc_dec.sv
// Registered Caesar-cipher engine: one ASCII char per clock, one-cycle latency, no flow control.
// Lowercase rotation is compiled in only when LOWERCASE_EN is defined; otherwise lowercase passes through.
module enc_dec #(
    parameter int DATA_W = 8,
    parameter int KEY_W  = 3
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic [DATA_W-1:0] inp,
    input  logic              select,
    input  logic [KEY_W-1:0]  key,
    output logic [DATA_W-1:0] out
);

    localparam logic [DATA_W-1:0] UP_A = DATA_W'(65);
    localparam logic [DATA_W-1:0] UP_Z = DATA_W'(90);

    // Six bits hold idx+key (<= 32) and idx+26-key without going negative.
    function automatic logic [4:0] rot(
        input logic [4:0]       idx,
        input logic             enc,
        input logic [KEY_W-1:0] k
    );
        logic [5:0] sum;
        if (enc)
            sum = {1'b0, idx} + 6'(k);
        else
            sum = {1'b0, idx} + 6'd26 - 6'(k);
        if (sum >= 6'd26)
            sum = sum - 6'd26;
        return sum[4:0];
    endfunction

    logic              is_upper;
    logic [4:0]        idx_upper;
    logic [DATA_W-1:0] nxt;

`ifdef LOWERCASE_EN
    localparam logic [DATA_W-1:0] LO_A = DATA_W'(97);
    localparam logic [DATA_W-1:0] LO_Z = DATA_W'(122);

    logic              is_lower;
    logic [4:0]        idx_lower;
`endif

    always_comb begin
        is_upper  = (inp >= UP_A) && (inp <= UP_Z);
        idx_upper = 5'(inp - UP_A);
        nxt       = inp;
        if (is_upper)
            nxt = UP_A + DATA_W'(rot(idx_upper, select, key));
`ifdef LOWERCASE_EN
        is_lower  = (inp >= LO_A) && (inp <= LO_Z);
        idx_lower = 5'(inp - LO_A);
        if (is_lower)
            nxt = LO_A + DATA_W'(rot(idx_lower, select, key));
`endif
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST)
            out <= '0;
        else
            out <= nxt;
    end

endmodule

// File: tb/tb_enc_dec.sv
// Directed and swept checks of enc_dec against hand values and an integer-modulo reference.
module tb_enc_dec;

    logic       CLK = 1'b0;
    logic       RST = 1'b0;
    logic [7:0] inp = 8'd0;
    logic       select = 1'b0;
    logic [2:0] key = 3'd0;
    logic [7:0] out;

    int n_checks = 0;
    int n_fail   = 0;

    enc_dec #(.DATA_W(8), .KEY_W(3)) dut (
        .CLK    (CLK),
        .RST    (RST),
        .inp    (inp),
        .select (select),
        .key    (key),
        .out    (out)
    );

    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic apply(input logic [7:0] c, input logic s, input logic [2:0] k);
        @(negedge CLK);
        inp    = c;
        select = s;
        key    = k;
        @(posedge CLK);
        #1;
    endtask

    function automatic logic [7:0] model(input int c, input bit enc, input int k);
        int b;
        b = -1;
        if (c >= 65 && c <= 90) b = 65;
`ifdef LOWERCASE_EN
        if (c >= 97 && c <= 122) b = 97;
`endif
        if (b < 0) return 8'(c);
        if (enc) return 8'(b + ((c - b + k) % 26));
        return 8'(b + ((c - b - k + 26) % 26));
    endfunction

    initial begin
        logic [7:0] e;

        #1 RST = 1'b1;
        #1 check("reset_async", out, 8'd0);
        @(posedge CLK); #1;
        check("reset_hold", out, 8'd0);
        @(negedge CLK);
        RST = 1'b0;

        apply(8'd65, 1'b1, 3'd3); check("enc_A_k3", out, 8'd68);
        apply(8'd91, 1'b1, 3'd3); check("pass_lbrk", out, 8'd91);
        apply(8'd64, 1'b1, 3'd3); check("pass_at", out, 8'd64);
        apply(8'd90, 1'b1, 3'd3); check("wrap_Z_enc", out, 8'd67);
        apply(8'd66, 1'b0, 3'd3); check("wrap_B_dec", out, 8'd89);
        apply(8'd65, 1'b0, 3'd1); check("wrap_A_dec", out, 8'd90);
        apply(8'd77, 1'b1, 3'd0); check("key0_M", out, 8'd77);
        apply(8'd72, 1'b1, 3'd7); check("enc_H_k7", out, 8'd79);
        // All three inputs change together; no mixing with the previous cycle.
        apply(8'd79, 1'b0, 3'd7); check("dec_O_k7", out, 8'd72);
`ifdef LOWERCASE_EN
        apply(8'd120, 1'b1, 3'd5); check("lower_x_k5", out, 8'd99);
        apply(8'd122, 1'b1, 3'd1); check("lower_z_k1", out, 8'd97);
        apply(8'd97, 1'b0, 3'd1);  check("lower_a_dec", out, 8'd122);
`else
        apply(8'd120, 1'b1, 3'd5); check("lower_x_k5", out, 8'd120);
        apply(8'd122, 1'b1, 3'd1); check("lower_z_k1", out, 8'd122);
        apply(8'd97, 1'b0, 3'd1);  check("lower_a_dec", out, 8'd97);
`endif

        // Mid-stream reset between edges.
        apply(8'd65, 1'b1, 3'd3); check("pre_rst", out, 8'd68);
        #2 RST = 1'b1;
        #1 check("rst_immediate", out, 8'd0);
        @(posedge CLK); #1;
        check("rst_held", out, 8'd0);
        @(negedge CLK);
        RST = 1'b0;
        #1 check("rst_released", out, 8'd0);
        @(posedge CLK); #1;
        check("post_rst", out, 8'd68);

        for (int c = 0; c < 256; c++) begin
            for (int k = 0; k < 8; k++) begin
                apply(8'(c), 1'b1, 3'(k));
                check("sweep_enc", out, model(c, 1'b1, k));
                e = out;
                apply(e, 1'b0, 3'(k));
                check("sweep_round", out, 8'(c));
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
